// File: rtl/reg_file.sv
// Register file with one write port and two independent combinational read ports,
// each entry carrying a written-since-reset flag. Define REG_FILE_BYPASS_EN for write-through.
module reg_file #(
  parameter int WIDTH  = 6,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  d_out_a,
  output logic              valid_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  d_out_b,
  output logic              valid_b
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            written_q, written_d;

  logic wr_in_range, rd_in_range_a, rd_in_range_b, wr_fire;

  assign wr_in_range   = ({1'b0, wr_addr}   < DEPTH_L);
  assign rd_in_range_a = ({1'b0, rd_addr_a} < DEPTH_L);
  assign rd_in_range_b = ({1'b0, rd_addr_b} < DEPTH_L);
  assign wr_fire       = sel && wr_in_range;

  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    if (wr_fire) begin
      mem_d[wr_addr]     = d_in;
      written_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '0;
      written_q <= '0;
    end else begin
      mem_q     <= mem_d;
      written_q <= written_d;
    end
  end

  // Out-of-range reads return zero with valid low; bypass overrides when enabled.
  always_comb begin
    d_out_a = '0;
    valid_a = 1'b0;
    if (rd_in_range_a) begin
      d_out_a = mem_q[rd_addr_a];
      valid_a = written_q[rd_addr_a];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_fire && !rst && (rd_addr_a == wr_addr)) begin
      d_out_a = d_in;
      valid_a = 1'b1;
    end
`endif
  end

  always_comb begin
    d_out_b = '0;
    valid_b = 1'b0;
    if (rd_in_range_b) begin
      d_out_b = mem_q[rd_addr_b];
      valid_b = written_q[rd_addr_b];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_fire && !rst && (rd_addr_b == wr_addr)) begin
      d_out_b = d_in;
      valid_b = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: default geometry, a DEPTH=3 instance for out-of-range
// behaviour and an 8x8 instance for the parameter sweep. Honours REG_FILE_BYPASS_EN.
module tb_reg_file;

  logic clk;
  logic rst;

  // Default geometry instance: WIDTH=6, DEPTH=4, ADDR_W=2
  logic       sel;
  logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [5:0] d_in, d_out_a, d_out_b;
  logic       valid_a, valid_b;

  // Short instance: DEPTH=3 so address 3 is out of range
  logic       sel3;
  logic [1:0] wr_addr3, rd_addr_a3, rd_addr_b3;
  logic [5:0] d_in3, d_out_a3, d_out_b3;
  logic       valid_a3, valid_b3;

  // Wide instance: WIDTH=8, DEPTH=8, ADDR_W=3
  logic       sel8;
  logic [2:0] wr_addr8, rd_addr_a8, rd_addr_b8;
  logic [7:0] d_in8, d_out_a8, d_out_b8;
  logic       valid_a8, valid_b8;

  int vectors;
  int miscompares;

  reg_file #(.WIDTH(6), .DEPTH(4), .ADDR_W(2)) u_dut (
    .clk(clk), .rst(rst), .sel(sel), .wr_addr(wr_addr), .d_in(d_in),
    .rd_addr_a(rd_addr_a), .d_out_a(d_out_a), .valid_a(valid_a),
    .rd_addr_b(rd_addr_b), .d_out_b(d_out_b), .valid_b(valid_b)
  );

  reg_file #(.WIDTH(6), .DEPTH(3), .ADDR_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .sel(sel3), .wr_addr(wr_addr3), .d_in(d_in3),
    .rd_addr_a(rd_addr_a3), .d_out_a(d_out_a3), .valid_a(valid_a3),
    .rd_addr_b(rd_addr_b3), .d_out_b(d_out_b3), .valid_b(valid_b3)
  );

  reg_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) u_dut8 (
    .clk(clk), .rst(rst), .sel(sel8), .wr_addr(wr_addr8), .d_in(d_in8),
    .rd_addr_a(rd_addr_a8), .d_out_a(d_out_a8), .valid_a(valid_a8),
    .rd_addr_b(rd_addr_b8), .d_out_b(d_out_b8), .valid_b(valid_b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    sel  = 1'b0; wr_addr  = '0; d_in  = '0; rd_addr_a  = '0; rd_addr_b  = '0;
    sel3 = 1'b0; wr_addr3 = '0; d_in3 = '0; rd_addr_a3 = '0; rd_addr_b3 = '0;
    sel8 = 1'b0; wr_addr8 = '0; d_in8 = '0; rd_addr_a8 = '0; rd_addr_b8 = '0;

    // Reset held for two cycles, then every address reads zero / invalid
    tick();
    tick();
    checkOutput("rst_hold_d_a", 32'(d_out_a), 32'h0);
    checkOutput("rst_hold_v_a", 32'(valid_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_addr_a = 2'(a);
      rd_addr_b = 2'(3 - a);
      #1;
      checkOutput($sformatf("rst_d_a[%0d]", a), 32'(d_out_a), 32'h0);
      checkOutput($sformatf("rst_v_a[%0d]", a), 32'(valid_a), 32'h0);
      checkOutput($sformatf("rst_d_b[%0d]", 3 - a), 32'(d_out_b), 32'h0);
      checkOutput($sformatf("rst_v_b[%0d]", 3 - a), 32'(valid_b), 32'h0);
    end

    // Write 2A to addr 1 and 15 to addr 3, read both back on separate ports
    sel = 1'b1; wr_addr = 2'd1; d_in = 6'h2A;
    tick();
    wr_addr = 2'd3; d_in = 6'h15;
    tick();
    sel = 1'b0;
    rd_addr_a = 2'd1; rd_addr_b = 2'd3;
    #1;
    checkOutput("wr_d_a1", 32'(d_out_a), 32'h2A);
    checkOutput("wr_v_a1", 32'(valid_a), 32'h1);
    checkOutput("wr_d_b3", 32'(d_out_b), 32'h15);
    checkOutput("wr_v_b3", 32'(valid_b), 32'h1);
    rd_addr_a = 2'd2; rd_addr_b = 2'd1;
    #1;
    checkOutput("unwr_v_a2", 32'(valid_a), 32'h0);
    checkOutput("unwr_d_a2", 32'(d_out_a), 32'h0);
    checkOutput("same_d_b1", 32'(d_out_b), 32'h2A);

    // Read-during-write on addr 2: old value without bypass, new value with it
    sel = 1'b1; wr_addr = 2'd2; d_in = 6'h3F; rd_addr_a = 2'd2;
    #1;
`ifdef REG_FILE_BYPASS_EN
    checkOutput("rdw_pre_d_a", 32'(d_out_a), 32'h3F);
    checkOutput("rdw_pre_v_a", 32'(valid_a), 32'h1);
`else
    checkOutput("rdw_pre_d_a", 32'(d_out_a), 32'h00);
    checkOutput("rdw_pre_v_a", 32'(valid_a), 32'h0);
`endif
    tick();
    sel = 1'b0;
    #1;
    checkOutput("rdw_post_d_a", 32'(d_out_a), 32'h3F);
    checkOutput("rdw_post_v_a", 32'(valid_a), 32'h1);

    // Back-to-back writes to addr 0: last one wins
    sel = 1'b1; wr_addr = 2'd0; d_in = 6'h0A;
    tick();
    d_in = 6'h0B;
    tick();
    sel = 1'b0; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    #1;
    checkOutput("b2b_d_a0", 32'(d_out_a), 32'h0B);
    checkOutput("b2b_d_b0", 32'(d_out_b), 32'h0B);
    checkOutput("b2b_v_b0", 32'(valid_b), 32'h1);

    // DEPTH=3 instance: out-of-range write ignored, sel=0 holds state
    sel3 = 1'b1; wr_addr3 = 2'd0; d_in3 = 6'h22;
    tick();
    wr_addr3 = 2'd3; d_in3 = 6'h11; rd_addr_a3 = 2'd3; rd_addr_b3 = 2'd3;
    #1;
    checkOutput("oor_pre_d_a3", 32'(d_out_a3), 32'h0);
    checkOutput("oor_pre_v_a3", 32'(valid_a3), 32'h0);
    tick();
    sel3 = 1'b0;
    #1;
    checkOutput("oor_d_a3", 32'(d_out_a3), 32'h0);
    checkOutput("oor_v_a3", 32'(valid_a3), 32'h0);
    checkOutput("oor_d_b3", 32'(d_out_b3), 32'h0);
    checkOutput("oor_v_b3", 32'(valid_b3), 32'h0);
    rd_addr_a3 = 2'd0; rd_addr_b3 = 2'd1;
    #1;
    checkOutput("oor_keep_d0", 32'(d_out_a3), 32'h22);
    checkOutput("oor_keep_v1", 32'(valid_b3), 32'h0);
    rd_addr_b3 = 2'd2;
    #1;
    checkOutput("oor_keep_v2", 32'(valid_b3), 32'h0);
    wr_addr3 = 2'd1;
    for (int k = 0; k < 4; k++) begin
      d_in3 = (k % 2 == 0) ? 6'h15 : 6'h2A;
      tick();
    end
    rd_addr_b3 = 2'd1;
    #1;
    checkOutput("hold_d_a0", 32'(d_out_a3), 32'h22);
    checkOutput("hold_d_b1", 32'(d_out_b3), 32'h0);
    checkOutput("hold_v_b1", 32'(valid_b3), 32'h0);

    // Wide instance sweep: addr*3 into each of the 8 entries
    sel8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_addr8 = 3'(i);
      d_in8    = 8'(i * 3);
      tick();
    end
    sel8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a8 = 3'(i);
      rd_addr_b8 = 3'(7 - i);
      #1;
      checkOutput($sformatf("sweep_d_a[%0d]", i), 32'(d_out_a8), 32'(i * 3));
      checkOutput($sformatf("sweep_v_a[%0d]", i), 32'(valid_a8), 32'h1);
      checkOutput($sformatf("sweep_d_b[%0d]", 7 - i), 32'(d_out_b8), 32'((7 - i) * 3));
      checkOutput($sformatf("sweep_v_b[%0d]", 7 - i), 32'(valid_b8), 32'h1);
    end

    // Async reset between edges while writing 07 to addr 0
    sel = 1'b1; wr_addr = 2'd0; d_in = 6'h07; rd_addr_a = 2'd0; rd_addr_b = 2'd1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_d_a0", 32'(d_out_a), 32'h0);
    checkOutput("arst_v_a0", 32'(valid_a), 32'h0);
    checkOutput("arst_d_b1", 32'(d_out_b), 32'h0);
    checkOutput("arst_v_b1", 32'(valid_b), 32'h0);
    checkOutput("arst_d8", 32'(d_out_a8), 32'h0);
    tick();
    checkOutput("arst_edge_d_a0", 32'(d_out_a), 32'h0);
    checkOutput("arst_edge_v_a0", 32'(valid_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_addr_a = 2'd1;
    #1;
    checkOutput("arst_rel_v_a1", 32'(valid_a), 32'h0);
    tick();
    sel = 1'b0;
    rd_addr_a = 2'd0;
    #1;
    checkOutput("first_wr_d_a0", 32'(d_out_a), 32'h07);
    checkOutput("first_wr_v_a0", 32'(valid_a), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
